// File: rtl/song_recorder_if.sv
// Note-entry bus between the recorder and whoever drives it: buttons and note operands in,
// packed song vectors and status out.
interface song_recorder_if #(
    parameter int unsigned MAX_NOTES = 75
) ();
    localparam int unsigned VecW = 4 * MAX_NOTES + 1;

    logic            rec_en;
    logic            btn_add;
    logic            btn_del;
    logic            btn_wipe;
    logic [3:0]      single_music;
    logic [1:0]      single_md;
    logic [VecW-1:0] rhyme;
    logic [VecW-1:0] md;
    logic [7:0]      how_long;
    logic            song_valid;
    logic            full;
    logic            ack;

    modport master (
        output rec_en, btn_add, btn_del, btn_wipe, single_music, single_md,
        input  rhyme, md, how_long, song_valid, full, ack
    );

    modport slave (
        input  rec_en, btn_add, btn_del, btn_wipe, single_music, single_md,
        output rhyme, md, how_long, song_valid, full, ack
    );
endinterface

// File: rtl/song_recorder.sv
// Note-entry stage: debounced ADD/DEL/WIPE buttons edit packed note/octave vectors that feed
// the player directly.
module song_recorder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_NOTES       = 75
) (
    input logic            clk100mhz,
    input logic            clr,
    song_recorder_if.slave bus
);
    localparam int unsigned    VecW   = 4 * MAX_NOTES + 1;
    localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     MaxLen = 8'(MAX_NOTES);

    typedef enum logic [0:0] {StIdle, StExec} state_e;
    typedef enum logic [1:0] {CmdAdd, CmdDel, CmdWipe} cmd_e;

    // Button vectors are ordered {wipe, del, add}.
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      stable_q, stable_d, rise;
    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];
    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [VecW-1:0] rhyme_q, rhyme_d, md_q, md_d;
    logic [7:0]      len_q, len_d;
    logic            ack_q, ack_d;
    logic            unused_music_msb;

    assign unused_music_msb = bus.single_music[3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            rise[i]     = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rhyme_d = rhyme_q;
        md_d    = md_q;
        len_d   = len_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only one command per cycle; lower-priority simultaneous events are dropped.
                if (bus.rec_en && (|rise)) begin
                    state_d = StExec;
                    if (rise[2])      cmd_d = CmdWipe;
                    else if (rise[1]) cmd_d = CmdDel;
                    else              cmd_d = CmdAdd;
                end
            end
            StExec: begin
                state_d = StIdle;
                unique case (cmd_q)
                    CmdAdd: begin
                        if (len_q < MaxLen) begin
                            for (int k = 0; k < int'(MAX_NOTES); k++) begin
                                if (8'(k) == len_q) begin
                                    rhyme_d[4*k +: 4] = {1'b0, bus.single_music[2:0]};
                                    md_d[4*k +: 4]    = {2'b00, bus.single_md};
                                end
                            end
                            len_d = len_q + 8'd1;
                            ack_d = 1'b1;
                        end
                    end
                    CmdDel: begin
                        if (len_q != 8'd0) begin
                            for (int k = 0; k < int'(MAX_NOTES); k++) begin
                                if (8'(k) == len_q - 8'd1) begin
                                    rhyme_d[4*k +: 4] = 4'h0;
                                    md_d[4*k +: 4]    = 4'h0;
                                end
                            end
                            len_d = len_q - 8'd1;
                            ack_d = 1'b1;
                        end
                    end
                    CmdWipe: begin
                        rhyme_d = '0;
                        md_d    = '0;
                        len_d   = 8'd0;
                        ack_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk100mhz or posedge clr) begin
        if (clr) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
            state_q  <= StIdle;
            cmd_q    <= CmdAdd;
            rhyme_q  <= '0;
            md_q     <= '0;
            len_q    <= 8'd0;
            ack_q    <= 1'b0;
        end else begin
            sync1_q  <= {bus.btn_wipe, bus.btn_del, bus.btn_add};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rhyme_q  <= rhyme_d;
            md_q     <= md_d;
            len_q    <= len_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.rhyme      = rhyme_q;
    assign bus.md         = md_q;
    assign bus.how_long   = len_q;
    assign bus.ack        = ack_q;
    assign bus.full       = (len_q == MaxLen);
    assign bus.song_valid = (len_q != 8'd0);
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: a reference model pushes expected song state per press,
// popped and compared once the press window has elapsed.
module tb_song_recorder;
    localparam int unsigned Deb  = 4;
    localparam int unsigned MaxN = 75;
    localparam int unsigned VecW = 4 * MaxN + 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    song_recorder_if #(.MAX_NOTES(MaxN)) bus ();

    song_recorder #(
        .DEBOUNCE_CYCLES(Deb),
        .MAX_NOTES      (MaxN)
    ) dut (
        .clk100mhz(clk),
        .clr      (clr),
        .bus      (bus)
    );

    typedef struct {
        int              len;
        logic [VecW-1:0] r;
        logic [VecW-1:0] m;
        int              acks;
    } exp_t;

    exp_t            sb[$];
    logic [VecW-1:0] m_r, m_m, all3;
    int              m_len;
    int              n_assert = 0;
    int              n_fail   = 0;
    int              ack_seen;

    task automatic chk(input string tag, input logic [VecW-1:0] obs, input logic [VecW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cmd: 0 none, 1 add, 2 del, 3 wipe
    task automatic expect_cmd(input int cmd, input logic [3:0] mus, input logic [1:0] octv);
        exp_t e;
        int   a;
        a = 0;
        if (cmd == 1 && m_len < int'(MaxN)) begin
            m_r[4*m_len +: 4] = {1'b0, mus[2:0]};
            m_m[4*m_len +: 4] = {2'b00, octv};
            m_len++;
            a = 1;
        end else if (cmd == 2 && m_len > 0) begin
            m_len--;
            m_r[4*m_len +: 4] = 4'h0;
            m_m[4*m_len +: 4] = 4'h0;
            a = 1;
        end else if (cmd == 3) begin
            m_r   = '0;
            m_m   = '0;
            m_len = 0;
            a     = 1;
        end
        e.len  = m_len;
        e.r    = m_r;
        e.m    = m_m;
        e.acks = a;
        sb.push_back(e);
    endtask

    task automatic count_ack();
        if (bus.ack === 1'b1) ack_seen++;
    endtask

    // btns ordered {wipe, del, add}
    task automatic press(input logic [2:0] btns, input logic [3:0] mus, input logic [1:0] octv,
                         input int bounce, input int hold);
        ack_seen = 0;
        @(negedge clk);
        bus.single_music = mus;
        bus.single_md    = octv;
        for (int i = 0; i < bounce; i++) begin
            {bus.btn_wipe, bus.btn_del, bus.btn_add} = (i % 2 == 0) ? btns : 3'b000;
            @(negedge clk);
            count_ack();
        end
        {bus.btn_wipe, bus.btn_del, bus.btn_add} = btns;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            count_ack();
        end
        {bus.btn_wipe, bus.btn_del, bus.btn_add} = 3'b000;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            count_ack();
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_len"}, VecW'(bus.how_long), VecW'(e.len));
            chk({tag, "_rhyme"}, bus.rhyme, e.r);
            chk({tag, "_md"}, bus.md, e.m);
            chk({tag, "_acks"}, VecW'(ack_seen), VecW'(e.acks));
            chk({tag, "_full"}, VecW'(bus.full), VecW'(e.len == int'(MaxN)));
            chk({tag, "_valid"}, VecW'(bus.song_valid), VecW'(e.len != 0));
        end
    endtask

    initial begin
        int lat;
        bit got;
        bus.rec_en       = 1'b1;
        bus.btn_add      = 1'b0;
        bus.btn_del      = 1'b0;
        bus.btn_wipe     = 1'b0;
        bus.single_music = 4'h0;
        bus.single_md    = 2'h0;
        m_r   = '0;
        m_m   = '0;
        m_len = 0;
        clr   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_len", VecW'(bus.how_long), '0);
        chk("reset_rhyme", bus.rhyme, '0);
        chk("reset_md", bus.md, '0);
        chk("reset_full", VecW'(bus.full), '0);
        chk("reset_valid", VecW'(bus.song_valid), '0);
        chk("reset_ack", VecW'(bus.ack), '0);
        clr = 1'b0;

        // Three ADDs; bit 3 of music is set on the last one and must be dropped.
        expect_cmd(1, 4'h1, 2'd1); press(3'b001, 4'h1, 2'd1, 0, 20); check_sb("add1");
        expect_cmd(1, 4'h5, 2'd0); press(3'b001, 4'h5, 2'd0, 0, 20); check_sb("add2");
        expect_cmd(1, 4'hF, 2'd2); press(3'b001, 4'hF, 2'd2, 0, 20); check_sb("add3");
        chk("s1_rhyme_low", VecW'(bus.rhyme[11:0]), VecW'(12'h751));
        chk("s1_md_low", VecW'(bus.md[11:0]), VecW'(12'h201));

        expect_cmd(2, 4'h0, 2'd0); press(3'b010, 4'h0, 2'd0, 0, 20); check_sb("del");
        chk("del_rhyme_low", VecW'(bus.rhyme[11:0]), VecW'(12'h051));
        chk("del_md_low", VecW'(bus.md[11:0]), VecW'(12'h001));

        expect_cmd(1, 4'h2, 2'd3); press(3'b001, 4'h2, 2'd3, 10, 20); check_sb("bounce");
        expect_cmd(0, 4'h4, 2'd1); press(3'b001, 4'h4, 2'd1, 0, 3);  check_sb("short");

        expect_cmd(3, 4'h0, 2'd0); press(3'b100, 4'h0, 2'd0, 0, 20); check_sb("wipe");
        expect_cmd(2, 4'h0, 2'd0); press(3'b010, 4'h0, 2'd0, 0, 20); check_sb("del_empty");
        expect_cmd(3, 4'h0, 2'd0); press(3'b100, 4'h0, 2'd0, 0, 20); check_sb("wipe_empty");

        expect_cmd(1, 4'h6, 2'd2); press(3'b001, 4'h6, 2'd2, 0, 20); check_sb("pre_a");
        expect_cmd(1, 4'h3, 2'd1); press(3'b001, 4'h3, 2'd1, 0, 20); check_sb("pre_b");
        expect_cmd(2, 4'h7, 2'd3); press(3'b011, 4'h7, 2'd3, 0, 20); check_sb("add_del_same");

        bus.rec_en = 1'b0;
        expect_cmd(0, 4'h5, 2'd1); press(3'b001, 4'h5, 2'd1, 0, 20); check_sb("noen_add");
        expect_cmd(0, 4'h5, 2'd1); press(3'b010, 4'h5, 2'd1, 0, 20); check_sb("noen_del");
        expect_cmd(0, 4'h5, 2'd1); press(3'b100, 4'h5, 2'd1, 0, 20); check_sb("noen_wipe");
        bus.rec_en = 1'b1;

        expect_cmd(3, 4'h0, 2'd0); press(3'b100, 4'h0, 2'd0, 0, 20); check_sb("wipe_fill");
        for (int n = 0; n < int'(MaxN); n++) begin
            expect_cmd(1, 4'h3, 2'd1); press(3'b001, 4'h3, 2'd1, 0, 20); check_sb("fill");
        end
        all3 = '0;
        for (int k = 0; k < int'(MaxN); k++) all3[4*k +: 4] = 4'h3;
        chk("fill_rhyme_all3", bus.rhyme, all3);
        chk("fill_bit300", VecW'(bus.rhyme[VecW-1]), '0);
        chk("fill_full", VecW'(bus.full), VecW'(1));
        expect_cmd(1, 4'h1, 2'd0); press(3'b001, 4'h1, 2'd0, 0, 20); check_sb("add_full");

        expect_cmd(3, 4'h0, 2'd0); press(3'b100, 4'h0, 2'd0, 0, 20); check_sb("wipe_pre_clr");
        for (int n = 0; n < 5; n++) begin
            expect_cmd(1, 4'h2, 2'd1); press(3'b001, 4'h2, 2'd1, 0, 20); check_sb("five");
        end

        // Reset in the middle of a debounce, with the button kept held through it.
        @(negedge clk);
        bus.single_music = 4'h4;
        bus.single_md    = 2'd2;
        bus.btn_add      = 1'b1;
        repeat (4) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_len", VecW'(bus.how_long), '0);
        chk("clr_rhyme", bus.rhyme, '0);
        chk("clr_md", bus.md, '0);
        chk("clr_valid", VecW'(bus.song_valid), '0);
        chk("clr_ack", VecW'(bus.ack), '0);
        m_r   = '0;
        m_m   = '0;
        m_len = 0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.ack === 1'b1) got = 1'b1;
        end
        chk("clr_held_ack_seen", VecW'(got), VecW'(1));
        n_assert++;
        assert (lat >= int'(Deb) + 2) else begin
            n_fail++;
            $error("FAIL clr_held_latency: observed %0d cycles expected at least %0d", lat, Deb + 2);
        end
        expect_cmd(1, 4'h4, 2'd2);
        ack_seen = 1;
        bus.btn_add = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            count_ack();
        end
        check_sb("clr_held_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
